// File: rtl/mod10_pkg.sv
// -----------------------------------------------------------------------------
// mod10_pkg
// Shared definitions for the decade counter slice:
//   MOD10_DEFAULT_MODULUS - default count length (10)
//   MOD10_DEFAULT_WIDTH   - default counter width (4)
//   count_t               - counter value type at the default width
// -----------------------------------------------------------------------------
package mod10_pkg;

    localparam int MOD10_DEFAULT_MODULUS = 10;
    localparam int MOD10_DEFAULT_WIDTH   = 4;

    typedef logic [MOD10_DEFAULT_WIDTH-1:0] count_t;

endpackage : mod10_pkg

// File: rtl/mod10_key_sync.sv
// -----------------------------------------------------------------------------
// mod10_key_sync
// Two-flop synchronizer for the count-enable key. Both stages clear to 0 while
// rst is low, so the counter never sees a stale enable coming out of reset.
// A change on key_in appears on key_sync after two rising clk edges.
//
// Ports:
//   clk      - in  : counter clock
//   rst      - in  : asynchronous active-low reset
//   key_in   - in  : raw count enable (may be asynchronous to clk)
//   key_sync - out : synchronized count enable
// -----------------------------------------------------------------------------
module mod10_key_sync (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_sync
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    // Next-state for the two synchronizer stages: a plain shift.
    always_comb begin
        meta_d = key_in;
        sync_d = meta_q;
    end

    // Synchronizer flops, cleared asynchronously by rst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign key_sync = sync_q;

endmodule : mod10_key_sync

// File: rtl/mod10_counter.sv
// -----------------------------------------------------------------------------
// mod10_counter
// Enable-gated modulo-MODULUS counter with a terminal-count enable output for
// cascading further stages (e.g. units -> tens).
//
// Parameters:
//   MODULUS - count length, 2..16 (default 10)
//   WIDTH   - width of out, needs 2**WIDTH >= MODULUS (default 4)
//
// Ports:
//   clk    - in  : single clock, all state changes on the rising edge
//   rst    - in  : asynchronous active-low reset, forces out to 0 at once
//   key    - in  : count enable, 1 = count, 0 = hold
//   out    - out : current count value (registered)
//   en_out - out : high while enabled at MODULUS-1, i.e. the cycle before wrap
//
// Build option:
//   MOD10_KEY_SYNC_EN - when defined, key passes through a two-flop
//                       synchronizer (mod10_key_sync) before use; otherwise
//                       key is used directly with no added latency.
// -----------------------------------------------------------------------------
module mod10_counter
    import mod10_pkg::*;
#(
    parameter int MODULUS = MOD10_DEFAULT_MODULUS,
    parameter int WIDTH   = MOD10_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key,
    output logic [WIDTH-1:0] out,
    output logic             en_out
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

    logic             key_eff_s;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

`ifdef MOD10_KEY_SYNC_EN
    mod10_key_sync u_key_sync (
        .clk      (clk),
        .rst      (rst),
        .key_in   (key),
        .key_sync (key_eff_s)
    );
`else
    assign key_eff_s = key;
`endif

    // Next count: hold when disabled; otherwise increment, wrapping to 0 at
    // LAST. Using >= also pulls any out-of-range value back to 0.
    always_comb begin
        count_d = count_q;
        if (key_eff_s) begin
            if (count_q >= LAST) begin
                count_d = ZERO;
            end else begin
                count_d = count_q + ONE;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= ZERO;
        end else begin
            count_q <= count_d;
        end
    end

    // Terminal-count enable: only the exact LAST value qualifies, so
    // out-of-range values never pulse the next stage.
    always_comb begin
        en_out = 1'b0;
        if (key_eff_s && (count_q == LAST)) begin
            en_out = 1'b1;
        end else begin
            en_out = 1'b0;
        end
    end

    assign out = count_q;

endmodule : mod10_counter

// File: tb/tb_mod10_counter.sv
// -----------------------------------------------------------------------------
// tb_mod10_counter
// Directed self-checking bench for mod10_counter at default parameters.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_mod10_counter;

    logic       clk;
    logic       rst;
    logic       key;
    logic [3:0] out;
    logic       en_out;

    int vectors;
    int miscompares;

    mod10_counter #(
        .MODULUS (10),
        .WIDTH   (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .key    (key),
        .out    (out),
        .en_out (en_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset for one edge with the given key value, released after that edge.
    task automatic do_reset(input logic kv);
        rst = 1'b0;
        key = kv;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        key = 1'b1;
        #1;
        vectors++;
        if (out !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_initial_out: got %0d expected 0", out);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (out !== 4'd0) begin
                miscompares++;
                $display("FAIL reset_held_out[%0d]: got %0d expected 0", i, out);
            end
            vectors++;
            if (en_out !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_held_en[%0d]: got %0b expected 0", i, en_out);
            end
        end
        rst = 1'b1;
    endtask

`ifndef MOD10_KEY_SYNC_EN
    task automatic test_count_wrap();
        logic [3:0] exp_out;
        logic       exp_en;
        do_reset(1'b1);
        for (int i = 0; i < 12; i++) begin
            tick();
            exp_out = 4'((i + 1) % 10);
            exp_en  = (exp_out == 4'd9);
            vectors++;
            if (out !== exp_out) begin
                miscompares++;
                $display("FAIL wrap_out[%0d]: got %0d expected %0d", i, out, exp_out);
            end
            vectors++;
            if (en_out !== exp_en) begin
                miscompares++;
                $display("FAIL wrap_en[%0d]: got %0b expected %0b", i, en_out, exp_en);
            end
        end
        // Asynchronous assertion well away from any clock edge (out is 2 here).
        #3;
        rst = 1'b0;
        #1;
        vectors++;
        if (out !== 4'd0) begin
            miscompares++;
            $display("FAIL async_reset_out: got %0d expected 0", out);
        end
        vectors++;
        if (en_out !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset_en: got %0b expected 0", en_out);
        end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_hold();
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) tick();
        vectors++;
        if (out !== 4'd4) begin
            miscompares++;
            $display("FAIL hold_reach4: got %0d expected 4", out);
        end
        key = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (out !== 4'd4) begin
                miscompares++;
                $display("FAIL hold_out[%0d]: got %0d expected 4", i, out);
            end
            vectors++;
            if (en_out !== 1'b0) begin
                miscompares++;
                $display("FAIL hold_en[%0d]: got %0b expected 0", i, en_out);
            end
        end
        key = 1'b1;
        tick();
        vectors++;
        if (out !== 4'd5) begin
            miscompares++;
            $display("FAIL hold_resume: got %0d expected 5", out);
        end
    endtask

    task automatic test_hold_terminal();
        // Continues from out=5 with key=1.
        for (int i = 0; i < 4; i++) tick();
        vectors++;
        if (out !== 4'd9 || en_out !== 1'b1) begin
            miscompares++;
            $display("FAIL term_reach9: got out=%0d en=%0b expected out=9 en=1", out, en_out);
        end
        key = 1'b0;
        #1;
        vectors++;
        if (en_out !== 1'b0) begin
            miscompares++;
            $display("FAIL term_key0_en: got %0b expected 0", en_out);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (out !== 4'd9 || en_out !== 1'b0) begin
                miscompares++;
                $display("FAIL term_hold[%0d]: got out=%0d en=%0b expected out=9 en=0", i, out, en_out);
            end
        end
        key = 1'b1;
        #1;
        vectors++;
        if (en_out !== 1'b1) begin
            miscompares++;
            $display("FAIL term_key1_en: got %0b expected 1", en_out);
        end
        tick();
        vectors++;
        if (out !== 4'd0) begin
            miscompares++;
            $display("FAIL term_wrap: got %0d expected 0", out);
        end
    endtask

    task automatic test_mid_reset();
        do_reset(1'b1);
        for (int i = 0; i < 5; i++) tick();
        vectors++;
        if (out !== 4'd5) begin
            miscompares++;
            $display("FAIL mid_reach5: got %0d expected 5", out);
        end
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (out !== 4'd0 || en_out !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_now: got out=%0d en=%0b expected out=0 en=0", out, en_out);
        end
        tick();
        vectors++;
        if (out !== 4'd0) begin
            miscompares++;
            $display("FAIL mid_reset_held: got %0d expected 0", out);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (out !== 4'd1) begin
            miscompares++;
            $display("FAIL mid_restart: got %0d expected 1", out);
        end
    endtask

    task automatic test_back_to_back();
        // Key toggles on consecutive edges; expected values hand-computed.
        logic       keys     [16] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                                      1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [3:0] exp_outs [16] = '{4'd1, 4'd2, 4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd5,
                                      4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd1, 4'd2};
        logic       exp_ens  [16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                      1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        do_reset(1'b0);
        for (int i = 0; i < 16; i++) begin
            key = keys[i];
            #1;
            vectors++;
            if (en_out !== exp_ens[i]) begin
                miscompares++;
                $display("FAIL b2b_en[%0d]: got %0b expected %0b", i, en_out, exp_ens[i]);
            end
            tick();
            vectors++;
            if (out !== exp_outs[i]) begin
                miscompares++;
                $display("FAIL b2b_out[%0d]: got %0d expected %0d", i, out, exp_outs[i]);
            end
        end
    endtask
`else
    task automatic test_key_sync();
        do_reset(1'b0);
        tick();
        tick();
        vectors++;
        if (out !== 4'd0) begin
            miscompares++;
            $display("FAIL sync_idle: got %0d expected 0", out);
        end
        key = 1'b1;
        tick();
        vectors++;
        if (out !== 4'd0) begin
            miscompares++;
            $display("FAIL sync_edge1: got %0d expected 0", out);
        end
        tick();
        vectors++;
        if (out !== 4'd0) begin
            miscompares++;
            $display("FAIL sync_edge2: got %0d expected 0", out);
        end
        tick();
        vectors++;
        if (out !== 4'd1) begin
            miscompares++;
            $display("FAIL sync_edge3: got %0d expected 1", out);
        end
        for (int i = 0; i < 8; i++) tick();
        vectors++;
        if (out !== 4'd9 || en_out !== 1'b1) begin
            miscompares++;
            $display("FAIL sync_term: got out=%0d en=%0b expected out=9 en=1", out, en_out);
        end
        // Dropping key still lets two more enabled edges through.
        key = 1'b0;
        tick();
        vectors++;
        if (out !== 4'd0) begin
            miscompares++;
            $display("FAIL sync_drop1: got %0d expected 0", out);
        end
        tick();
        vectors++;
        if (out !== 4'd1) begin
            miscompares++;
            $display("FAIL sync_drop2: got %0d expected 1", out);
        end
        tick();
        vectors++;
        if (out !== 4'd1 || en_out !== 1'b0) begin
            miscompares++;
            $display("FAIL sync_drop3: got out=%0d en=%0b expected out=1 en=0", out, en_out);
        end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        key         = 1'b0;
        test_reset();
`ifndef MOD10_KEY_SYNC_EN
        test_count_wrap();
        test_hold();
        test_hold_terminal();
        test_mid_reset();
        test_back_to_back();
`else
        test_key_sync();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_mod10_counter
